// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage constants and helpers for inst_fetch.
// FETCH_PERF_CNT_EN selects the optional performance counters in the top.
package inst_fetch_pkg;

   localparam int unsigned ROM_ADDR_W       = 10;
   localparam int unsigned INST_W           = 32;
   localparam int unsigned RESET_PC_DEFAULT = 0;

   typedef logic [31:0] perf_cnt_t;

   function automatic perf_cnt_t sat_inc(input perf_cnt_t v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// Synchronous fetch FIFO with flush; head read directly from register storage.
module inst_fetch_queue #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 42
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  logic [WIDTH-1:0]             wr_data,
   output logic [WIDTH-1:0]             rd_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (push && !flush && !reset) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];

   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(push && !pop && !flush && count == CNT_W'(DEPTH)));
   a_no_underflow: assert property (@(posedge clk) disable iff (reset)
      !(pop && count == '0));

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC, ROM address, in-flight tracking, credit-based issue and redirect squash.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int unsigned ADDR_W      = ROM_ADDR_W,
   parameter int unsigned RESET_PC    = RESET_PC_DEFAULT,
   parameter int unsigned QUEUE_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [INST_W-1:0] rom_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [ADDR_W-1:0] inst_pc,
   output logic [INST_W-1:0] inst_data
`ifdef FETCH_PERF_CNT_EN
   ,
   output perf_cnt_t         perf_fetched,
   output perf_cnt_t         perf_stall
`endif
);

   localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

   logic [ADDR_W-1:0]        pc_fetch;
   logic [ADDR_W-1:0]        inflight_pc;
   logic                     inflight_vld;
   logic [ADDR_W-1:0]        redirect_tgt;
   logic [CNT_W-1:0]         count;
   logic [CNT_W:0]           occupancy;
   logic                     pop;
   logic                     push;
   logic                     issue;
   logic [ADDR_W+INST_W-1:0] head;

   assign redirect_tgt = redirect_pc & ~ADDR_W'(3);
   assign rom_address  = redirect_valid ? redirect_tgt : pc_fetch;

   assign inst_valid = (count != '0) && !redirect_valid && !reset;
   assign pop        = inst_valid && inst_ready;
   // A redirect squashes the word returning this cycle.
   assign push       = inflight_vld && !redirect_valid && !reset;

   assign occupancy = {1'b0, count} + (CNT_W + 1)'(inflight_vld) - (CNT_W + 1)'(pop);

   always_comb begin
      issue = 1'b0;
      if (!reset) begin
         issue = redirect_valid || (occupancy < (CNT_W + 1)'(QUEUE_DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_fetch     <= ADDR_W'(RESET_PC);
         inflight_pc  <= ADDR_W'(RESET_PC);
         inflight_vld <= 1'b0;
      end else begin
         inflight_vld <= issue;
         if (issue) begin
            inflight_pc <= rom_address;
            pc_fetch    <= rom_address + ADDR_W'(4);
         end
      end
   end

   inst_fetch_queue #(
      .DEPTH (QUEUE_DEPTH),
      .WIDTH (ADDR_W + INST_W)
   ) u_queue (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .pop     (pop),
      .flush   (redirect_valid),
      .wr_data ({inflight_pc, rom_data}),
      .rd_data (head),
      .count   (count)
   );

   assign inst_pc   = head[ADDR_W+INST_W-1:INST_W];
   assign inst_data = head[INST_W-1:0];

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (pop) perf_fetched <= sat_inc(perf_fetched);
         if (!inst_valid && !redirect_valid) perf_stall <= sat_inc(perf_stall);
      end
   end
`endif

endmodule
